// File: rtl/lookup_inversemapping_table_pipe_pkg.sv
// Shared definitions for the pipelined inverse-mapping lookup.
//   - Default field widths (FLOWID_W, BUFID_W, DMAC_W, ADDR_W)
//   - FSM state encoding shared by the top and any debug tooling
//   - Entry field offsets: a RAM entry is {flowid, dmac}, dmac in the low bits
package lookup_imt_pkg;

    localparam int FLOWID_W = 14;
    localparam int BUFID_W  = 9;
    localparam int DMAC_W   = 48;
    localparam int ADDR_W   = 8;

    // dmac occupies the LSBs of an entry; flowid sits directly above it
    localparam int ENTRY_DMAC_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESULT = 2'd2
    } imt_state_e;

endpackage

// File: rtl/lookup_inversemapping_table_pipe_rd_pipe.sv
// imt_rd_latency_pipe: DEPTH-deep shift register tracking outstanding RAM
// reads as {valid, index}, so each returning data beat can be tagged with
// the address it belongs to.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_flush         : synchronous clear of every in-flight entry
//   i_push_vld/idx  : read issued this cycle and its address
//   o_pop_vld/idx   : tag aligned with the RAM data arriving now
module imt_rd_latency_pipe #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push_vld,
    input  logic [IDX_W-1:0] iv_push_idx,
    output logic             o_pop_vld,
    output logic [IDX_W-1:0] ov_pop_idx
);

    logic [DEPTH-1:0]            vld_q;
    logic [DEPTH-1:0][IDX_W-1:0] idx_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q[0] <= i_push_vld;
            idx_q[0] <= iv_push_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign o_pop_vld  = vld_q[DEPTH-1];
    assign ov_pop_idx = idx_q[DEPTH-1];

endmodule

// File: rtl/lookup_inversemapping_table_pipe.sv
// Pipelined inverse-mapping lookup. Accepts a {flowid, bufid} descriptor,
// streams reads over table addresses 0..entry_num-1 (one per cycle), checks
// each returning beat in address order and reports the first hit (or a miss)
// on a valid/ready result port. Saturating hit/miss counters tick when a
// result is accepted downstream.
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   iv_descriptor/i_descriptor_wr/o_descriptor_ready : descriptor input
//   iv_entry_num                 : number of entries to search, 0..2^ADDR_W
//   o_ram_rd/ov_ram_raddr/iv_ram_rdata : table RAM, RAM_LAT read latency
//   ov_dmac/ov_bufid/o_lookup_table_match_flag/o_descriptor_wr/i_descriptor_ready : result
//   ov_hit_cnt/ov_miss_cnt       : statistics
module lookup_inversemapping_table_pipe
    import lookup_imt_pkg::*;
#(
    parameter int FLOWID_W = lookup_imt_pkg::FLOWID_W,
    parameter int BUFID_W  = lookup_imt_pkg::BUFID_W,
    parameter int DMAC_W   = lookup_imt_pkg::DMAC_W,
    parameter int ADDR_W   = lookup_imt_pkg::ADDR_W,
    parameter int RAM_LAT  = 2,
    parameter int CNT_W    = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [FLOWID_W+BUFID_W-1:0] iv_descriptor,
    input  logic                       i_descriptor_wr,
    output logic                       o_descriptor_ready,
    input  logic [ADDR_W:0]            iv_entry_num,
    input  logic [FLOWID_W+DMAC_W-1:0] iv_ram_rdata,
    output logic                       o_ram_rd,
    output logic [ADDR_W-1:0]          ov_ram_raddr,
    output logic [DMAC_W-1:0]          ov_dmac,
    output logic [BUFID_W-1:0]         ov_bufid,
    output logic                       o_lookup_table_match_flag,
    output logic                       o_descriptor_wr,
    input  logic                       i_descriptor_ready,
    output logic [CNT_W-1:0]           ov_hit_cnt,
    output logic [CNT_W-1:0]           ov_miss_cnt
);

    localparam int FLOWID_LSB = ENTRY_DMAC_LSB + DMAC_W;

    imt_state_e          state_q, state_d;
    logic                ram_rd_q, ram_rd_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [FLOWID_W-1:0] flowid_q, flowid_d;
    logic [BUFID_W-1:0]  bufid_q, bufid_d;
    logic [ADDR_W:0]     entry_num_q, entry_num_d;
    logic                res_wr_q, res_wr_d;
    logic [DMAC_W-1:0]   res_dmac_q, res_dmac_d;
    logic [BUFID_W-1:0]  res_bufid_q, res_bufid_d;
    logic                res_flag_q, res_flag_d;
    logic [CNT_W-1:0]    hit_q, hit_d;
    logic [CNT_W-1:0]    miss_q, miss_d;
    logic                flush;

    logic                pop_vld;
    logic [ADDR_W-1:0]   pop_idx;
    logic [ADDR_W:0]     last_idx;
    logic                beat_zero, beat_hit, beat_last;

    imt_rd_latency_pipe #(
        .DEPTH (RAM_LAT),
        .IDX_W (ADDR_W)
    ) u_rd_pipe (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_flush     (flush),
        .i_push_vld  (ram_rd_q),
        .iv_push_idx (raddr_q),
        .o_pop_vld   (pop_vld),
        .ov_pop_idx  (pop_idx)
    );

    // Kept ADDR_W+1 wide so entry_num = 2^ADDR_W yields last address 2^ADDR_W-1
    // without wrapping. Only consulted in SEARCH, where entry_num is nonzero.
    assign last_idx  = entry_num_q - 1'b1;
    assign beat_zero = (iv_ram_rdata == '0);
    assign beat_hit  = (iv_ram_rdata[FLOWID_LSB +: FLOWID_W] == flowid_q);
    assign beat_last = ({1'b0, pop_idx} == last_idx);

    always_comb begin
        state_d     = state_q;
        ram_rd_d    = ram_rd_q;
        raddr_d     = raddr_q;
        flowid_d    = flowid_q;
        bufid_d     = bufid_q;
        entry_num_d = entry_num_q;
        res_wr_d    = res_wr_q;
        res_dmac_d  = res_dmac_q;
        res_bufid_d = res_bufid_q;
        res_flag_d  = res_flag_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        flush       = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_descriptor_wr) begin
                    flowid_d    = iv_descriptor[BUFID_W +: FLOWID_W];
                    bufid_d     = iv_descriptor[BUFID_W-1:0];
                    entry_num_d = iv_entry_num;
                    if (iv_entry_num == '0) begin
                        // Empty table: immediate miss, no RAM traffic
                        state_d     = RESULT;
                        res_wr_d    = 1'b1;
                        res_dmac_d  = '0;
                        res_bufid_d = iv_descriptor[BUFID_W-1:0];
                        res_flag_d  = 1'b0;
                    end else begin
                        state_d  = SEARCH;
                        ram_rd_d = 1'b1;
                        raddr_d  = '0;
                    end
                end
            end

            SEARCH: begin
                if (ram_rd_q) begin
                    if ({1'b0, raddr_q} == last_idx) begin
                        ram_rd_d = 1'b0;
                        raddr_d  = '0;
                    end else begin
                        raddr_d = raddr_q + 1'b1;
                    end
                end
                // Zero entry beats a flowid match, which beats end-of-range
                if (pop_vld && (beat_zero || beat_hit || beat_last)) begin
                    flush       = 1'b1;
                    ram_rd_d    = 1'b0;
                    raddr_d     = '0;
                    state_d     = RESULT;
                    res_wr_d    = 1'b1;
                    res_bufid_d = bufid_q;
                    res_flag_d  = !beat_zero && beat_hit;
                    res_dmac_d  = (!beat_zero && beat_hit) ?
                                  iv_ram_rdata[ENTRY_DMAC_LSB +: DMAC_W] : '0;
                end
            end

            RESULT: begin
                if (i_descriptor_ready) begin
                    state_d     = IDLE;
                    res_wr_d    = 1'b0;
                    res_dmac_d  = '0;
                    res_bufid_d = '0;
                    res_flag_d  = 1'b0;
                    if (res_flag_q) begin
                        if (hit_q != {CNT_W{1'b1}}) hit_d = hit_q + 1'b1;
                    end else begin
                        if (miss_q != {CNT_W{1'b1}}) miss_d = miss_q + 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            ram_rd_q    <= 1'b0;
            raddr_q     <= '0;
            flowid_q    <= '0;
            bufid_q     <= '0;
            entry_num_q <= '0;
            res_wr_q    <= 1'b0;
            res_dmac_q  <= '0;
            res_bufid_q <= '0;
            res_flag_q  <= 1'b0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            ram_rd_q    <= ram_rd_d;
            raddr_q     <= raddr_d;
            flowid_q    <= flowid_d;
            bufid_q     <= bufid_d;
            entry_num_q <= entry_num_d;
            res_wr_q    <= res_wr_d;
            res_dmac_q  <= res_dmac_d;
            res_bufid_q <= res_bufid_d;
            res_flag_q  <= res_flag_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

    assign o_descriptor_ready        = (state_q == IDLE);
    assign o_ram_rd                  = ram_rd_q;
    assign ov_ram_raddr              = raddr_q;
    assign o_descriptor_wr           = res_wr_q;
    assign ov_dmac                   = res_dmac_q;
    assign ov_bufid                  = res_bufid_q;
    assign o_lookup_table_match_flag = res_flag_q;
    assign ov_hit_cnt                = hit_q;
    assign ov_miss_cnt               = miss_q;

endmodule

// File: tb/tb_lookup_inversemapping_table_pipe.sv
// Directed bench with a scoreboard: each issued descriptor pushes its expected
// result (fields plus the cycle o_descriptor_wr must rise); a negedge monitor
// pops and compares whenever a new result appears.
module tb_lookup_inversemapping_table_pipe;

    localparam int FW = 14, BW = 9, DW = 48, AW = 8, LAT = 2, CW = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [FW+BW-1:0]   desc;
    logic               dwr;
    logic               d_ready;
    logic [AW:0]        entry;
    logic [FW+DW-1:0]   ram_rdata;
    logic               ram_rd;
    logic [AW-1:0]      ram_raddr;
    logic [DW-1:0]      dmac;
    logic [BW-1:0]      bufid;
    logic               flag;
    logic               res_wr;
    logic               res_ready;
    logic [CW-1:0]      hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    lookup_inversemapping_table_pipe #(
        .FLOWID_W(FW), .BUFID_W(BW), .DMAC_W(DW), .ADDR_W(AW), .RAM_LAT(LAT), .CNT_W(CW)
    ) dut (
        .i_clk                     (clk),
        .i_rst                     (rst),
        .iv_descriptor             (desc),
        .i_descriptor_wr           (dwr),
        .o_descriptor_ready        (d_ready),
        .iv_entry_num              (entry),
        .iv_ram_rdata              (ram_rdata),
        .o_ram_rd                  (ram_rd),
        .ov_ram_raddr              (ram_raddr),
        .ov_dmac                   (dmac),
        .ov_bufid                  (bufid),
        .o_lookup_table_match_flag (flag),
        .o_descriptor_wr           (res_wr),
        .i_descriptor_ready        (res_ready),
        .ov_hit_cnt                (hit_cnt),
        .ov_miss_cnt               (miss_cnt)
    );

    // RAM model with LAT-cycle read latency
    logic [FW+DW-1:0] mem [0:(1<<AW)-1];
    logic [LAT-1:0][FW+DW-1:0] rpipe;
    always @(posedge clk) begin
        rpipe[0] <= ram_rd ? mem[ram_raddr] : '0;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_rdata = rpipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] dmac;
        logic [BW-1:0] bufid;
        logic          flag;
        int            t;
    } exp_t;
    exp_t q[$];

    // Monitor: read statistics and result scoreboard
    int rd_total = 0;
    int rd_at [0:(1<<AW)-1];
    logic prev_wr = 1'b0;
    initial for (int i = 0; i < (1<<AW); i++) rd_at[i] = 0;

    always @(negedge clk) begin
        exp_t e;
        if (ram_rd) begin
            rd_total++;
            rd_at[ram_raddr]++;
        end
        if (res_wr && !prev_wr) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got dmac=%0h bufid=%0h flag=%0b, expected none",
                         dmac, bufid, flag);
            end else begin
                e = q.pop_front();
                check("result_fields", {dmac, bufid, flag}, {e.dmac, e.bufid, e.flag});
                // Rising here means it is sampled at the next edge, cyc+1
                check("result_latency", cyc + 1, e.t);
            end
        end
        prev_wr = res_wr;
    end

    task automatic clr_mem();
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    endtask

    // Called at #1 after a posedge; returns the accept edge number
    task automatic issue(input logic [FW-1:0] fid, input logic [BW-1:0] bid, input logic [AW:0] en,
                         input logic [DW-1:0] edmac, input logic eflag, input int lat,
                         input bit expect_res, output int t0);
        check("ready_before_accept", d_ready, 1'b1);
        desc  = {fid, bid};
        entry = en;
        dwr   = 1'b1;
        @(posedge clk); #1;
        t0  = cyc;
        dwr = 1'b0;
        if (expect_res) q.push_back('{edmac, bid, eflag, t0 + lat});
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (!(q.size() == 0 && !res_wr && d_ready) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle_timeout", (q.size() == 0 && !res_wr && d_ready), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, r0, a3;
        logic [DW-1:0] s_dmac;
        logic [BW-1:0] s_bufid;
        logic          s_flag;
        int n;

        rst = 1'b1; dwr = 1'b0; res_ready = 1'b1; desc = '0; entry = '0;
        clr_mem();
        repeat (3) @(posedge clk); #1;
        check("rst_wr", res_wr, 1'b0);
        check("rst_ready", d_ready, 1'b1);
        check("rst_ram_rd", {ram_rd, ram_raddr}, '0);
        check("rst_outputs", {dmac, bufid, flag}, '0);
        check("rst_counters", {hit_cnt, miss_cnt}, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Hit at entry 0
        mem[0] = {14'h5, 48'hAABB_CCDD_EEFF};
        issue(14'h5, 9'h1A, 9'd4, 48'hAABB_CCDD_EEFF, 1'b1, 4, 1, t0);
        wait_idle(30);
        check("hit_cnt_t1", hit_cnt, 1);

        // Hit at entry 3 of 4
        clr_mem();
        mem[0] = {14'h6, 48'h1}; mem[1] = {14'h7, 48'h2};
        mem[2] = {14'h8, 48'h3}; mem[3] = {14'h5, 48'h1234_5678_9ABC};
        r0 = rd_total;
        issue(14'h5, 9'h0F, 9'd4, 48'h1234_5678_9ABC, 1'b1, 7, 1, t0);
        wait_idle(30);
        check("reads_t2", rd_total - r0, 4);

        // Range ends before the matching entry
        r0 = rd_total; a3 = rd_at[3];
        issue(14'h5, 9'h155, 9'd3, 48'h0, 1'b0, 6, 1, t0);
        wait_idle(30);
        check("reads_t3", rd_total - r0, 3);
        check("addr3_unread_t3", rd_at[3] - a3, 0);
        check("miss_cnt_t3", miss_cnt, 1);

        // Zero entry at address 1 ends the table before a later match
        clr_mem();
        mem[0] = {14'h6, 48'h1}; mem[2] = {14'h5, 48'hFFFF_0000_FFFF};
        issue(14'h5, 9'h021, 9'd4, 48'h0, 1'b0, 5, 1, t0);
        wait_idle(30);
        check("cnt_t4", {hit_cnt, miss_cnt}, {32'd2, 32'd2});

        // Duplicate flowid: lowest address wins
        clr_mem();
        mem[0] = {14'h9, 48'h5}; mem[1] = {14'h5, 48'h1111_1111_1111};
        mem[2] = {14'h5, 48'h2222_2222_2222};
        issue(14'h5, 9'h0AA, 9'd4, 48'h1111_1111_1111, 1'b1, 5, 1, t0);
        wait_idle(30);
        check("hit_cnt_dup", hit_cnt, 3);

        // Backpressure: result held while ready is low, new descriptor ignored
        clr_mem();
        mem[0] = {14'h5, 48'hAABB_CCDD_EEFF};
        res_ready = 1'b0;
        issue(14'h5, 9'h1A, 9'd4, 48'hAABB_CCDD_EEFF, 1'b1, 4, 1, t0);
        n = 0;
        while (!res_wr && n < 20) begin @(posedge clk); #1; n++; end
        check("bp_result_seen", res_wr, 1'b1);
        s_dmac = dmac; s_bufid = bufid; s_flag = flag;
        desc = {14'h5, 9'h077}; entry = 9'd1; dwr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold", {res_wr, d_ready, dmac, bufid, flag},
                  {1'b1, 1'b0, s_dmac, s_bufid, s_flag});
        end
        dwr = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_accepted", {res_wr, d_ready, dmac, bufid, flag}, {2'b01, 58'h0});
        check("hit_cnt_bp", hit_cnt, 4);
        repeat (8) @(posedge clk); #1;

        // Reset mid-search, then an empty-table descriptor
        clr_mem();
        mem[1] = {14'h5, 48'hDEAD_BEEF_0001}; mem[3] = {14'h5, 48'hDEAD_BEEF_0003};
        issue(14'h5, 9'h033, 9'd4, 48'h0, 1'b0, 0, 0, t0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_state", {res_wr, d_ready, ram_rd}, 3'b010);
        check("midrst_counters", {hit_cnt, miss_cnt}, '0);
        r0 = rd_total;
        issue(14'h9, 9'h044, 9'd0, 48'h0, 1'b0, 1, 1, t0);
        wait_idle(30);
        check("reads_empty", rd_total - r0, 0);
        check("miss_cnt_empty", {hit_cnt, miss_cnt}, {32'd0, 32'd1});

        repeat (10) @(posedge clk); #1;
        check("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
